// File: rtl/wb_slave_bfm_if.sv
// wb_slave_bfm_if: Wishbone bus between a master and the slave BFM.
interface wb_slave_bfm_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   ADR;
    logic [DW-1:0]   DAT_W;
    logic [DW-1:0]   DAT_R;
    logic            CYC;
    logic            STB;
    logic            WE;
    logic [DW/8-1:0] SEL;
    logic [2:0]      CTI;
    logic [1:0]      BTE;
    logic            ACK;
    logic            ERR;
    modport master (output ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE, input DAT_R, ACK, ERR);
    modport slave (input ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE, output DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_slave_bfm.sv
// wb_slave_bfm: Wishbone responder with word memory, wait states, error injection and burst address checking.
module wb_slave_bfm #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    wb_slave_bfm_if.slave bus,
    input  logic [3:0]    wait_cycles,
    input  logic          err_inject,
    output logic [31:0]   wr_count,
    output logic [31:0]   rd_count,
    output logic          protocol_err
);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam logic [AW-1:0] LOW = AW'((64'd1 << LB) - 64'd1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t r_state, w_next;
    logic [DW-1:0]            r_mem [2**MEM_ADDR_BITS];
    logic [AW-1:0]            r_adr, r_exp_adr;
    logic [DW-1:0]            r_dat, r_dat_r;
    logic [NB-1:0]            r_sel;
    logic [2:0]               r_cti;
    logic [1:0]               r_bte;
    logic [3:0]               r_wcnt;
    logic [MEM_ADDR_BITS-1:0] r_idx;
    logic                     r_we, r_is_err, r_burst, r_ack, r_err, r_perr;
    logic [31:0]              r_wr_cnt, r_rd_cnt;
    logic [AW:0]              w_diff;
    logic [AW-1:0]            w_win, w_inc, w_mask, w_nxt_adr;
    logic                     w_oor, w_load, w_abort, w_resp, w_ok_wr, w_ok_rd;
    always_comb begin
        w_diff    = {1'b0, bus.ADR} - {1'b0, BASE_ADDR};
        w_oor     = w_diff[AW] | (((w_diff[AW-1:0] >> LB) >> MEM_ADDR_BITS) != '0);
        w_load    = (r_state == IDLE) & bus.CYC & bus.STB;
        w_abort   = (r_state == WAIT) & ~bus.CYC;
        w_resp    = r_state == RESP;
        w_ok_wr   = w_resp & ~r_is_err & r_we;
        w_ok_rd   = w_resp & ~r_is_err & ~r_we;
        w_win     = r_adr >> LB;
        w_inc     = w_win + 1'b1;
        // Wrapping bursts only advance the low index bits; linear carries through all of them.
        w_mask    = r_bte == 2'b01 ? AW'(3) : r_bte == 2'b10 ? AW'(7) : r_bte == 2'b11 ? AW'(15) : '1;
        w_nxt_adr = (((w_win & ~w_mask) | (w_inc & w_mask)) << LB) | (r_adr & LOW);
        w_next    = r_state;
        if (w_load)
            w_next = wait_cycles == 4'd0 ? RESP : WAIT;
        else if (w_abort || w_resp)
            w_next = IDLE;
        else if (r_state == WAIT && r_wcnt == 4'd1)
            w_next = RESP;
    end
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_dat_r   <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_perr    <= 1'b0;
            r_burst   <= 1'b0;
            r_exp_adr <= '0;
            r_wcnt    <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_cti     <= '0;
            r_bte     <= '0;
            r_we      <= 1'b0;
            r_is_err  <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_ack   <= w_resp & ~r_is_err;
            r_err   <= w_resp & r_is_err;
            r_dat_r <= w_ok_rd ? r_mem[r_idx] : '0;
            if (w_ok_wr)
                r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_ok_rd)
                r_rd_cnt <= r_rd_cnt + 32'd1;
            if (r_state == WAIT)
                r_wcnt <= r_wcnt - 4'd1;
            if (w_load) begin
                r_adr    <= bus.ADR;
                r_we     <= bus.WE;
                r_sel    <= bus.SEL;
                r_dat    <= bus.DAT_W;
                r_cti    <= bus.CTI;
                r_bte    <= bus.BTE;
                r_wcnt   <= wait_cycles;
                r_is_err <= err_inject | w_oor;
                r_idx    <= MEM_ADDR_BITS'(w_diff[AW-1:0] >> LB);
                if (r_burst && bus.ADR != r_exp_adr)
                    r_perr <= 1'b1;
            end
            if (w_resp && r_cti == 3'b010) begin
                r_burst   <= 1'b1;
                r_exp_adr <= w_nxt_adr;
            end else if ((w_resp && (r_cti == 3'b000 || r_cti == 3'b111)) || w_abort || (r_state == IDLE && !bus.CYC))
                r_burst <= 1'b0;
        end
    end
    // Memory is deliberately left out of reset so contents survive a bench-level reset.
    always_ff @(posedge clk) begin
        if (!rst && w_ok_wr)
            for (int b = 0; b < NB; b++)
                if (r_sel[b])
                    r_mem[r_idx][8*b +: 8] <= r_dat[8*b +: 8];
    end
    assign bus.ACK      = r_ack;
    assign bus.ERR      = r_err;
    assign bus.DAT_R    = r_dat_r;
    assign wr_count     = r_wr_cnt;
    assign rd_count     = r_rd_cnt;
    assign protocol_err = r_perr;
endmodule

// File: tb/tb_wb_slave_bfm.sv
// tb_wb_slave_bfm: directed bench for the Wishbone slave BFM.
module tb_wb_slave_bfm;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wait_cycles;
    logic        err_inject;
    logic [31:0] wr_count, rd_count;
    logic        protocol_err;
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat;
    logic        got_ack, got_err, seen;
    logic [31:0] got_dat;
    wb_slave_bfm_if #(.AW(32), .DW(32)) bus ();
    wb_slave_bfm dut (
        .clk(clk), .rst(rst), .bus(bus), .wait_cycles(wait_cycles), .err_inject(err_inject),
        .wr_count(wr_count), .rd_count(rd_count), .protocol_err(protocol_err)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat,
                        input logic [2:0] cti, input logic [1:0] bte, input bit keep);
        bus.ADR = adr; bus.WE = we; bus.SEL = sel; bus.DAT_W = dat; bus.CTI = cti; bus.BTE = bte;
        bus.CYC = 1'b1; bus.STB = 1'b1;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
        while (lat < 40 && !(got_ack || got_err)) begin
            tick(1);
            lat++;
            got_ack = bus.ACK; got_err = bus.ERR; got_dat = bus.DAT_R;
        end
        if (!(got_ack || got_err)) lat = -1;
        if (!keep) begin
            bus.CYC = 1'b0; bus.STB = 1'b0;
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        n_checks++; if (bus.ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.ACK); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.ERR); end
        n_checks++; if (bus.DAT_R !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", bus.DAT_R); end
        n_checks++; if (wr_count !== 32'd0 || rd_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts: got wr=%0d rd=%0d expected 0/0", wr_count, rd_count); end
        n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", protocol_err); end
        rst = 1'b0;
    endtask
    task automatic test_single;
        xfer(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 3'b000, 2'b00, 0);
        n_checks++; if (lat !== 2 || got_ack !== 1'b1 || got_err !== 1'b0) begin n_fail++; $display("FAIL single_wr_term: got lat=%0d ack=%b err=%b expected 2/1/0", lat, got_ack, got_err); end
        tick(1);
        n_checks++; if (bus.ACK !== 1'b0 || wr_count !== 32'd1) begin n_fail++; $display("FAIL single_wr_after: got ack=%b wr=%0d expected 0/1", bus.ACK, wr_count); end
        xfer(32'h10, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (lat !== 2 || got_ack !== 1'b1 || got_dat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rd: got lat=%0d ack=%b dat=%h expected 2/1/deadbeef", lat, got_ack, got_dat); end
        tick(1);
        n_checks++; if (bus.DAT_R !== 32'h0 || rd_count !== 32'd1) begin n_fail++; $display("FAIL single_rd_after: got dat=%h rd=%0d expected 0/1", bus.DAT_R, rd_count); end
    endtask
    task automatic test_byte_lanes;
        xfer(32'h20, 1'b1, 4'hF, 32'h11223344, 3'b000, 2'b00, 0);
        tick(1);
        xfer(32'h20, 1'b1, 4'b0010, 32'h0000AA00, 3'b000, 2'b00, 0);
        tick(1);
        xfer(32'h20, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (got_dat !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_lane: got %h expected 1122aa44", got_dat); end
        tick(1);
        n_checks++; if (wr_count !== 32'd3 || rd_count !== 32'd2) begin n_fail++; $display("FAIL byte_counts: got wr=%0d rd=%0d expected 3/2", wr_count, rd_count); end
    endtask
    task automatic test_wait_abort;
        wait_cycles = 4'd3;
        xfer(32'h10, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (lat !== 5 || got_dat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wait3_rd: got lat=%0d dat=%h expected 5/deadbeef", lat, got_dat); end
        tick(1);
        bus.ADR = 32'h20; bus.WE = 1'b0; bus.CTI = 3'b000; bus.CYC = 1'b1; bus.STB = 1'b1;
        tick(2);
        seen = bus.ACK | bus.ERR;
        bus.CYC = 1'b0; bus.STB = 1'b0;
        repeat (6) begin
            tick(1);
            seen = seen | bus.ACK | bus.ERR;
        end
        n_checks++; if (seen !== 1'b0 || rd_count !== 32'd3) begin n_fail++; $display("FAIL abort: got term=%b rd=%0d expected 0/3", seen, rd_count); end
        wait_cycles = 4'd0;
        xfer(32'h20, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (lat !== 2 || got_dat !== 32'h1122AA44) begin n_fail++; $display("FAIL after_abort: got lat=%0d dat=%h expected 2/1122aa44", lat, got_dat); end
        tick(1);
    endtask
    task automatic test_errors;
        xfer(32'h0, 1'b1, 4'hF, 32'hCAFEF00D, 3'b000, 2'b00, 0);
        tick(1);
        xfer(32'h1000, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (lat !== 2 || got_err !== 1'b1 || got_ack !== 1'b0 || got_dat !== 32'h0) begin n_fail++; $display("FAIL oor_rd: got lat=%0d err=%b ack=%b dat=%h expected 2/1/0/0", lat, got_err, got_ack, got_dat); end
        tick(1);
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", bus.ERR); end
        err_inject = 1'b1;
        xfer(32'h0, 1'b1, 4'hF, 32'h12345678, 3'b000, 2'b00, 0);
        err_inject = 1'b0;
        n_checks++; if (got_err !== 1'b1 || got_ack !== 1'b0) begin n_fail++; $display("FAIL inject_wr: got err=%b ack=%b expected 1/0", got_err, got_ack); end
        tick(1);
        n_checks++; if (wr_count !== 32'd4 || rd_count !== 32'd4) begin n_fail++; $display("FAIL err_counts: got wr=%0d rd=%0d expected 4/4", wr_count, rd_count); end
        xfer(32'h0, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (got_dat !== 32'hCAFEF00D) begin n_fail++; $display("FAIL inject_nowrite: got %h expected cafef00d", got_dat); end
        tick(1);
    endtask
    task automatic test_burst;
        int acks;
        int lat_bad;
        logic [31:0] adrs [4];
        logic [2:0]  ctis [4];
        adrs = '{32'h0C, 32'h00, 32'h04, 32'h08};
        ctis = '{3'b010, 3'b010, 3'b010, 3'b111};
        acks = 0;
        lat_bad = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(adrs[i], 1'b1, 4'hF, 32'hA0 + 32'(i), ctis[i], 2'b01, i != 3);
            if (got_ack) acks++;
            if (lat != 2) lat_bad++;
        end
        n_checks++; if (acks !== 4 || lat_bad !== 0) begin n_fail++; $display("FAIL wrap4_acks: got acks=%0d slow=%0d expected 4/0", acks, lat_bad); end
        tick(1);
        n_checks++; if (protocol_err !== 1'b0 || wr_count !== 32'd8) begin n_fail++; $display("FAIL wrap4_state: got perr=%b wr=%0d expected 0/8", protocol_err, wr_count); end
        xfer(32'h04, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (got_dat !== 32'hA2) begin n_fail++; $display("FAIL wrap4_data: got %h expected a2", got_dat); end
        tick(1);
        xfer(32'h00, 1'b0, 4'hF, 32'h0, 3'b010, 2'b00, 1);
        xfer(32'h08, 1'b0, 4'hF, 32'h0, 3'b111, 2'b00, 0);
        n_checks++; if (got_ack !== 1'b1 || protocol_err !== 1'b1) begin n_fail++; $display("FAIL linear_skip: got ack=%b perr=%b expected 1/1", got_ack, protocol_err); end
        tick(4);
        n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b expected 1", protocol_err); end
    endtask
    task automatic test_reset_mid;
        wait_cycles = 4'd4;
        bus.ADR = 32'h10; bus.WE = 1'b1; bus.SEL = 4'hF; bus.DAT_W = 32'h55555555; bus.CTI = 3'b000;
        bus.CYC = 1'b1; bus.STB = 1'b1;
        tick(2);
        rst = 1'b1; bus.CYC = 1'b0; bus.STB = 1'b0;
        tick(1);
        n_checks++; if (bus.ACK !== 1'b0 || bus.ERR !== 1'b0 || bus.DAT_R !== 32'h0 || wr_count !== 32'd0 || rd_count !== 32'd0 || protocol_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: got ack=%b err=%b dat=%h wr=%0d rd=%0d perr=%b expected all 0", bus.ACK, bus.ERR, bus.DAT_R, wr_count, rd_count, protocol_err); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick(1);
            seen = seen | bus.ACK | bus.ERR;
        end
        n_checks++; if (seen !== 1'b0 || wr_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset_quiet: got term=%b wr=%0d expected 0/0", seen, wr_count); end
        wait_cycles = 4'd0;
        xfer(32'h10, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 0);
        n_checks++; if (got_dat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_reset_mem: got %h expected deadbeef", got_dat); end
        tick(1);
        n_checks++; if (rd_count !== 32'd1) begin n_fail++; $display("FAIL mid_reset_rd: got %0d expected 1", rd_count); end
    endtask
    initial begin
        rst = 1'b1; wait_cycles = 4'd0; err_inject = 1'b0;
        bus.ADR = '0; bus.DAT_W = '0; bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
        bus.SEL = '0; bus.CTI = '0; bus.BTE = '0;
        test_reset;
        test_single;
        test_byte_lanes;
        test_wait_abort;
        test_errors;
        test_burst;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
